// File: rtl/mul_issue_unit.sv
// mul_issue_unit: EX-stage front end for the RV32M multiplies (MUL, MULH,
// MULHSU, MULHU). It registers the operands into an external multiplier,
// waits out MUL_LATENCY edges, picks or corrects the 32-bit result word,
// and holds it on a valid/ready response port.
// Optional feature macro: MUL_RESULT_CACHE_EN keeps the last 64-bit product
// so that a repeat of the same operands and signedness skips the multiplier.
module mul_issue_unit #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_sign,
  input  logic [63:0] mul_product
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY);

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [1:0]  op_reg;
  logic        rs1_msb_reg;

  logic        req_sign;
  logic        take_req;
  logic        capture;
  logic        hit_now;
  logic        hit_reg;
  logic [63:0] capture_product;
  logic [31:0] capture_b;

  // Only funct3[1:0] selects the operation; bit 2 is fixed by the decoder.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  // MUL and MULH multiply signed x signed; MULHSU/MULHU run unsigned and
  // MULHSU is corrected afterwards.
  assign req_sign = ~funct3[1];
  assign req_ready = (state_reg == IDLE);
  assign take_req  = (state_reg == IDLE) && req_valid && !flush;
  assign capture   = (state_reg == WAIT) && (cnt_reg == 3'd0) && !flush;

  // Picks the result word; MULHSU is derived from the unsigned high word by
  // subtracting rs2 when rs1 was negative (rs1 as signed = rs1u - 2^32).
  function automatic logic [31:0] select_result(
    input logic [1:0]  op,
    input logic [63:0] prod,
    input logic        a_msb,
    input logic [31:0] b
  );
    logic [31:0] word;
    case (op)
      2'b00:   word = prod[31:0];
      2'b10:   word = prod[63:32] - (a_msb ? b : 32'd0);
      default: word = prod[63:32];
    endcase
    return word;
  endfunction

`ifdef MUL_RESULT_CACHE_EN
  logic        cache_valid_reg;
  logic [31:0] cache_a_reg;
  logic [31:0] cache_b_reg;
  logic        cache_sign_reg;
  logic [63:0] cache_product_reg;

  assign hit_now = cache_valid_reg && (cache_a_reg == rs1) &&
                   (cache_b_reg == rs2) && (cache_sign_reg == req_sign);

  // On a hit the capture reads the stored product; the stored operand b is
  // used for the MULHSU correction because mul_b may have moved since.
  assign capture_product = hit_reg ? cache_product_reg : mul_product;
  assign capture_b       = hit_reg ? cache_b_reg : mul_b;

  // Result cache: written only by a real multiplier capture, cleared only by
  // reset, untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_reg           <= 1'b0;
      cache_valid_reg   <= 1'b0;
      cache_a_reg       <= 32'd0;
      cache_b_reg       <= 32'd0;
      cache_sign_reg    <= 1'b0;
      cache_product_reg <= 64'd0;
    end else begin
      if (take_req) begin
        hit_reg <= hit_now;
      end
      if (capture && !hit_reg) begin
        cache_valid_reg   <= 1'b1;
        cache_a_reg       <= mul_a;
        cache_b_reg       <= mul_b;
        cache_sign_reg    <= mul_sign;
        cache_product_reg <= mul_product;
      end
    end
  end
`else
  assign hit_now         = 1'b0;
  assign hit_reg         = 1'b0;
  assign capture_product = mul_product;
  assign capture_b       = mul_b;
`endif

  // Issue FSM: accept, count down the multiplier latency, capture, hold.
  // A cache hit enters WAIT with a zero count so the response still lands
  // one edge after the accept, without touching the multiplier operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      op_reg      <= 2'b00;
      rs1_msb_reg <= 1'b0;
      mul_a       <= 32'd0;
      mul_b       <= 32'd0;
      mul_sign    <= 1'b0;
      resp_data   <= 32'd0;
      resp_valid  <= 1'b0;
    end else if (flush) begin
      state_reg  <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg      <= funct3[1:0];
            rs1_msb_reg <= rs1[31];
            state_reg   <= WAIT;
            if (hit_now) begin
              cnt_reg <= 3'd0;
            end else begin
              mul_a    <= rs1;
              mul_b    <= rs2;
              mul_sign <= req_sign;
              cnt_reg  <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else begin
            resp_data  <= select_result(op_reg, capture_product, rs1_msb_reg, capture_b);
            resp_valid <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          state_reg  <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Self-checking bench for mul_issue_unit. A behavioural multiplier with a
// configurable pipeline depth feeds mul_product; expected responses are
// queued when a request is issued and popped when the response appears.
module tb_mul_issue_unit;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic [63:0] mul_product;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // bench-side view of the result cache (only consulted when enabled)
  bit          c_valid = 0;
  logic [31:0] c_a = 0;
  logic [31:0] c_b = 0;
  logic        c_s = 0;

  mul_issue_unit #(.MUL_LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .funct3(funct3),
    .rs1(rs1),
    .rs2(rs2),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_sign(mul_sign),
    .mul_product(mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier model: product appears LAT edges after the operands change
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_sign)
      mpipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else
      mpipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_product = mpipe[LAT-1];

  // RV32M reference computed from sign/zero-extended 64-bit products
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00:   p = {32'd0, a} * {32'd0, b};
      2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b10:   p = {{32{a[31]}}, a} * {32'd0, b};
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input bit push);
    logic s;
    bit   hit;
    exp_t e;
    s   = ~op[1];
    hit = 0;
`ifdef MUL_RESULT_CACHE_EN
    hit = c_valid && (c_a == a) && (c_b == b) && (c_s == s);
`endif
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    funct3    = {1'b0, op};
    rs1       = a;
    rs2       = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (push) begin
      e.data = exp_data;
      e.lat  = hit ? 8'd1 : 8'(LAT + 1);
      sb.push_back(e);
      if (!hit) begin
        c_valid = 1; c_a = a; c_b = b; c_s = s;
      end
    end
    $display("issue op=%0d a=%h b=%h exp=%h hit=%0d", op, a, b, exp_data, hit);
  endtask

  // Wait for a response, compare it, hold it `hold` cycles, then take it.
  task automatic get_resp(input string tag, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      check({tag, "_timeout"}, {31'd0, resp_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, lat, {24'd0, e.lat});
    check({tag, "_data"}, resp_data, e.data);
    check({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_bp_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_bp_data"}, resp_data, e.data);
      check({tag, "_bp_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
    $display("resp %s data=%h lat=%0d hold=%0d", tag, e.data, lat, hold);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b0; req_valid = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    flush = 1'b0; resp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_mul_sign", {31'd0, mul_sign}, 32'd0);
    rst = 1'b1;

    // MUL and high-word operations
    issue(2'b00, 32'hFFFFFE0C, 32'd499, 32'hFFFC3164, 1);
    check("mul_a_latched", mul_a, 32'hFFFFFE0C);
    check("mul_sign_mul", {31'd0, mul_sign}, 32'd1);
    get_resp("mul", 0);
    issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1);
    get_resp("mulh", 0);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    check("mul_sign_mulhu", {31'd0, mul_sign}, 32'd0);
    get_resp("mulhu_bp", 3);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    get_resp("mulhsu", 0);

    // flush during WAIT
    issue(2'b00, 32'd11, 32'd13, 32'd143, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_wait_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (LAT + 3) @(negedge clk);
    check("flush_wait_no_resp", {31'd0, resp_valid}, 32'd0);

    // flush together with req_valid in IDLE: nothing accepted
    req_valid = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd99; rs2 = 32'd98;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("flush_idle_mul_a", mul_a, 32'd11);
    check("flush_idle_mul_b", mul_b, 32'd13);
    repeat (LAT + 2) @(negedge clk);
    check("flush_idle_no_resp", {31'd0, resp_valid}, 32'd0);
    issue(2'b00, 32'd3, 32'd5, 32'h0000000F, 1);
    get_resp("mul_after_flush", 0);

    // flush wins over resp_ready in DONE
    issue(2'b00, 32'd6, 32'd7, 32'd42, 0);
    c_valid = 1; c_a = 32'd6; c_b = 32'd7; c_s = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("done_valid", {31'd0, resp_valid}, 32'd1);
    check("done_data", resp_data, 32'd42);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    check("flush_done_valid", {31'd0, resp_valid}, 32'd0);
    check("flush_done_req_ready", {31'd0, req_ready}, 32'd1);

    // asynchronous reset in the middle of WAIT
    issue(2'b00, 32'd1234, 32'd5678, 32'd0, 0);
    rst = 1'b0;
    #1;
    check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstw_resp_data", resp_data, 32'd0);
    check("rstw_mul_a", mul_a, 32'd0);
    check("rstw_mul_b", mul_b, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    c_valid = 0;
    repeat (LAT + 3) @(negedge clk);
    check("rstw_no_resp", {31'd0, resp_valid}, 32'd0);

    // same operands, different op: second one may come from the cache
    issue(2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 1);
    get_resp("cache_mulh", 0);
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    check("cache_mul_a", mul_a, 32'd7);
    get_resp("cache_mul", 0);

    // random operations, occasionally reusing the previous operands
    ra = 32'd0; rb = 32'd0;
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        ra = $urandom();
        rb = $urandom();
      end
      issue(rop, ra, rb, ref_mul(rop, ra, rb), 1);
      get_resp("rand", int'($urandom_range(0, 2)));
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
